// File: rtl/ps2_key_sequencer_pkg.sv
// Shared PS/2 definitions: protocol prefix bytes, sequencer state encoding
// and the key-event record carried through the key FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_BREAK = 3'd2,
    ST_DROP  = 3'd3,
    ST_WAIT  = 3'd4
  } ps2_seq_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Key-event stream from the sequencer to its consumer (valid/ready, FWFT head).
interface ps2_key_sequencer_if;

  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_ext;

  modport master (
    output key_valid,
    output key_code,
    output key_ext,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_ext,
    output key_ready
  );

endinterface

// File: rtl/ps2_key_fifo.sv
// First-word fall-through FIFO with valid/ready pop, occupancy count and a
// one-cycle drop pulse when a push is refused because the FIFO is full.
module ps2_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             pop;
  logic             wr_en;

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts
  // a simultaneous push.
  always_comb begin
    full    = (count_q == CNT_W'(DEPTH));
    pop     = (count_q != '0) && out_ready;
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;
    rd_d    = rd_q + PTR_W'(pop);
    wr_d    = wr_q + PTR_W'(wr_en);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: turns raw bytes into key events (E0 extension,
// typematic suppression, stray-break rejection, post-release lockout).
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int WAIT_CYCLES = 5000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_W       = $clog2(WAIT_CYCLES+1)
) (
  input  logic                                CLOCK_50,
  input  logic                                rst_n,
  input  logic [7:0]                          rx_data,
  input  logic                                rx_en,
  input  logic                                step_en,
  input  logic                                clr_ovf,
  ps2_key_sequencer_if.master                 key_if,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                step,
  output logic                                held,
  output logic                                overflow
);

  ps2_seq_state_t   state_q, state_d;
  logic             ext_q, ext_d;
  logic [7:0]       code_q, code_d;
  logic             cext_q, cext_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             step_q, step_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             fifo_drop;
  key_evt_t         push_evt;
  key_evt_t         head_evt;

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    code_d   = code_q;
    cext_d   = cext_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    step_d   = 1'b0;
    push     = 1'b0;
    push_evt = '{ext: ext_q, code: rx_data};

    case (state_q)
      ST_IDLE: if (rx_en) begin
        if (rx_data == PS2_EXT) begin
          ext_d = 1'b1;
        end else if (rx_data == PS2_BRK) begin
          state_d = ST_DROP;
        end else begin
          code_d  = rx_data;
          cext_d  = ext_q;
          ext_d   = 1'b0;
          push    = 1'b1;
          held_d  = 1'b1;
          state_d = ST_PRESS;
        end
      end
      // Repeats of the held code are typematic; other codes are rollover noise.
      ST_PRESS: if (rx_en) begin
        if (rx_data == code_q) begin
          ext_d = ext_q;
        end else if (rx_data == PS2_EXT) begin
          ext_d = 1'b1;
        end else if (rx_data == PS2_BRK) begin
          state_d = ST_BREAK;
        end else begin
          ext_d = 1'b0;
        end
      end
      ST_BREAK: if (rx_en) begin
        ext_d = 1'b0;
        if ((rx_data == code_q) && (ext_q == cext_q)) begin
          step_d  = step_en;
          held_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_PRESS;
        end
      end
      ST_DROP: if (rx_en) begin
        ext_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES-1)) state_d = ST_IDLE;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_d = fifo_drop || (ovf_q && !clr_ovf);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ext_q   <= 1'b0;
      code_q  <= '0;
      cext_q  <= 1'b0;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      step_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      code_q  <= code_d;
      cext_q  <= cext_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      step_q  <= step_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(key_evt_t))
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_evt),
    .out_ready (key_if.key_ready),
    .out_valid (key_if.key_valid),
    .out_data  (head_evt),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign key_if.key_code = head_evt.code;
  assign key_if.key_ext  = head_evt.ext;
  assign step            = step_q;
  assign held            = held_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: vector table, directed corner sequences and a
// randomized run against an event-level reference model.
module tb_ps2_key_sequencer;
  import ps2_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = '0;
  logic       rx_en    = 1'b0;
  logic       step_en  = 1'b0;
  logic       clr_ovf  = 1'b0;
  logic [2:0] fifo_count;
  logic       step, held, overflow;

  ps2_key_sequencer_if kif();

  ps2_key_sequencer #(.WAIT_CYCLES(W), .FIFO_DEPTH(D)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_en      (rx_en),
    .step_en    (step_en),
    .clr_ovf    (clr_ovf),
    .key_if     (kif),
    .fifo_count (fifo_count),
    .step       (step),
    .held       (held),
    .overflow   (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  // Reference model: tracks events, not states.
  logic [8:0] mq[$];
  bit         m_down, m_brk, m_drop_nx, m_ext, m_kext, m_step, m_ovf;
  logic [7:0] m_code;
  int         t_edge, lock_end;

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       kr;
    logic       kv;
    logic [7:0] code;
    logic       ext;
    logic [2:0] cnt;
    logic       st;
    logic       hd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic [7:0] d, logic kr, logic kv,
                              logic [7:0] code, logic ext, logic [2:0] cnt,
                              logic st, logic hd);
    vec_t v;
    v.en = en; v.d = d; v.kr = kr; v.kv = kv; v.code = code;
    v.ext = ext; v.cnt = cnt; v.st = st; v.hd = hd;
    return v;
  endfunction

  function automatic logic [15:0] ex(logic kv, logic [7:0] code, logic ext,
                                     logic [2:0] cnt, logic st, logic hd, logic ov);
    return {kv, code, ext, cnt, st, hd, ov};
  endfunction

  function automatic logic [15:0] outs();
    return {kif.key_valid, kif.key_code, kif.key_ext, fifo_count, step, held, overflow};
  endfunction

  function automatic logic [15:0] model_outs();
    logic [8:0] h;
    h = (mq.size() > 0) ? mq[0] : 9'h000;
    return {mq.size() > 0, h[7:0], h[8], 3'(mq.size()), m_step, m_down, m_ovf};
  endfunction

  task automatic chk(string nm, logic [15:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got {kv,code,ext,cnt,step,held,ovf}=%h expected %h", nm, outs(), exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_down = 0; m_brk = 0; m_drop_nx = 0; m_ext = 0; m_kext = 0;
    m_step = 0; m_ovf = 0; m_code = '0;
    lock_end = -1000;
  endtask

  task automatic model_edge(logic en, logic [7:0] d, logic kr, logic se, logic clr);
    bit pop, push, drop;
    logic [8:0] pd;
    t_edge++;
    m_step = 0;
    pop  = (mq.size() > 0) && kr;
    push = 0;
    drop = 0;
    pd   = '0;
    if (en && t_edge > lock_end) begin
      if (m_drop_nx) begin
        m_drop_nx = 0;
        m_ext     = 0;
      end else if (!m_down) begin
        if (d == PS2_EXT) m_ext = 1;
        else if (d == PS2_BRK) m_drop_nx = 1;
        else begin
          push = 1; pd = {m_ext, d};
          m_code = d; m_kext = m_ext; m_ext = 0; m_down = 1;
        end
      end else if (!m_brk) begin
        if (d == m_code) ;
        else if (d == PS2_EXT) m_ext = 1;
        else if (d == PS2_BRK) m_brk = 1;
        else m_ext = 0;
      end else begin
        m_brk = 0;
        if (d == m_code && m_ext == m_kext) begin
          m_step   = se;
          m_down   = 0;
          lock_end = t_edge + W;
        end
        m_ext = 0;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < D) mq.push_back(pd);
      else drop = 1;
    end
    m_ovf = drop || (m_ovf && !clr);
  endtask

  task automatic cyc(logic en, logic [7:0] d, logic kr, logic se, logic clr);
    rx_en = en; rx_data = d; kif.key_ready = kr; step_en = se; clr_ovf = clr;
    @(posedge CLOCK_50);
    model_edge(en, d, kr, se, clr);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    rst_n = 1'b0;
    rx_en = 1'b0; kif.key_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] keys [5];
    logic [7:0] pool [7];
    kif.key_ready = 1'b0;
    t_edge = 0;
    model_reset();
    keys = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    pool = '{8'h1C, 8'h32, 8'h75, 8'hE0, 8'hF0, 8'hF0, 8'h21};

    tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8'h1C, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h1C, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 8'h1C, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h1C, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h1C, 0, 1, 0, 1));
    tbl.push_back(mk(1, 8'h1C, 0, 1, 8'h1C, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'hE0, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hE0, 0, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'hE0, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'hF0, 0, 1, 8'h75, 1, 1, 0, 1));
    tbl.push_back(mk(1, 8'h75, 0, 1, 8'h75, 1, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0));

    // Reset state
    #2;
    chk("in_reset", 16'h0000);
    do_reset();
    chk("after_reset", 16'h0000);

    // Vector table: basic press, typematic, extended key, ext mismatch, lockout edge
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].en, tbl[i].d, tbl[i].kr, 1'b1, 1'b0);
      chk($sformatf("tbl[%0d]", i),
          ex(tbl[i].kv, tbl[i].code, tbl[i].ext, tbl[i].cnt, tbl[i].st, tbl[i].hd, 1'b0));
    end
    idle(W);

    // Overflow, clear, set-wins-over-clear, simultaneous push/pop when full
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, keys[i], 1'b0, 1'b1, 1'b0);
      cyc(1'b1, PS2_BRK, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, keys[i], 1'b0, 1'b1, 1'b0);
      idle(W);
      if (i == 3) chk("ovf_four", ex(1, 8'h1C, 0, 3'd4, 0, 0, 0));
    end
    chk("ovf_full", ex(1, 8'h1C, 0, 3'd4, 0, 0, 1));
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("ovf_clr", ex(1, 8'h1C, 0, 3'd4, 0, 0, 0));
    cyc(1'b1, 8'h25, 1'b0, 1'b1, 1'b1);
    chk("ovf_set_wins", ex(1, 8'h1C, 0, 3'd4, 0, 1, 1));
    cyc(1'b1, PS2_BRK, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h25, 1'b0, 1'b1, 1'b0);
    chk("ovf_release", ex(1, 8'h1C, 0, 3'd4, 1, 0, 1));
    idle(W);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 8'h26, 1'b1, 1'b1, 1'b0);
    chk("push_pop_full", ex(1, 8'h32, 0, 3'd4, 0, 1, 0));
    cyc(1'b1, PS2_BRK, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h26, 1'b0, 1'b1, 1'b0);
    idle(W);

    // Step gating, lockout discard, stray break
    do_reset();
    cyc(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("gate_make", ex(1, 8'h1C, 0, 3'd1, 0, 1, 0));
    cyc(1'b1, PS2_BRK, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("gate_nostep", ex(1, 8'h1C, 0, 3'd1, 0, 0, 0));
    cyc(1'b1, 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("wait_discard", ex(1, 8'h1C, 0, 3'd1, 0, 0, 0));
    idle(W - 1);
    cyc(1'b1, PS2_BRK, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("stray_nopush", ex(1, 8'h1C, 0, 3'd1, 0, 0, 0));
    cyc(1'b1, 8'h32, 1'b0, 1'b1, 1'b0);
    chk("after_drop", ex(1, 8'h1C, 0, 3'd2, 0, 1, 0));

    // Asynchronous reset while in PRESS with two entries
    @(negedge CLOCK_50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 16'h0000);
    model_reset();
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    cyc(1'b1, 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("post_rst_make", ex(1, 8'h1C, 0, 3'd1, 0, 1, 0));
    cyc(1'b1, PS2_BRK, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("post_rst_step", ex(1, 8'h1C, 0, 3'd1, 1, 0, 0));
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("post_rst_step_once", ex(1, 8'h1C, 0, 3'd1, 0, 0, 0));
    idle(W);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 1) == 1), pool[$urandom_range(0, 6)],
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0));
      chk($sformatf("rand[%0d]", i), model_outs());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
